// File: rtl/i_fetch_pkg.sv
// Shared types for the instruction fetch slice: opcodes, queue entry, fetch FSM states.
package i_fetch_pkg;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [31:0] instr;
  } i_queue_data_t;

  typedef enum logic [1:0] {
    FETCH,
    DISCARD,
    HOLD
  } fetch_st_t;

  function automatic logic [31:0] j_imm(input logic [31:0] instr);
    return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/i_fetch_if.sv
// Fetch-side bus bundle: instruction cache read port plus instruction queue write port.
interface i_fetch_if;
  import i_fetch_pkg::*;

  logic          imem_read;
  logic [31:0]   imem_address;
  logic [31:0]   imem_rdata;
  logic          imem_resp;
  logic          iq_full;
  logic          iq_write;
  i_queue_data_t iq_data;

  modport master (
    output imem_read, imem_address, iq_write, iq_data,
    input  imem_rdata, imem_resp, iq_full
  );

  modport slave (
    input  imem_read, imem_address, iq_write, iq_data,
    output imem_rdata, imem_resp, iq_full
  );

endinterface

// File: rtl/i_fetch_hold_buf.sv
// Single-entry skid register that parks a fetched entry while the queue is full.
module i_fetch_hold_buf
  import i_fetch_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          clear,
  input  i_queue_data_t din,
  output logic          valid,
  output i_queue_data_t data
);

  logic          valid_q, valid_d;
  i_queue_data_t data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) valid_d = 1'b0;
    if (load) begin
      valid_d = 1'b1;
      data_d  = din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/i_fetch.sv
// Instruction fetch unit: owns the fetch PC, reads the I-cache, writes the instruction queue.
// Optional JAL next-PC prediction enabled by defining IFETCH_JAL_PREDICT_EN.
module i_fetch
  import i_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input  logic        clk,
  input  logic        rst,
  i_fetch_if.master   bus,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  fetch_st_t     state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   pend_q, pend_d;
  logic [31:0]   target;
  logic [31:0]   pred_pc;
  i_queue_data_t fetched;
  logic          hb_load, hb_clear, hb_valid;
  i_queue_data_t hb_data;

  assign target = redirect_pc & ~32'h3;

  always_comb begin
`ifdef IFETCH_JAL_PREDICT_EN
    if (bus.imem_rdata[6:0] == op_jal) pred_pc = pc_q + j_imm(bus.imem_rdata);
    else                               pred_pc = pc_q + 32'd4;
`else
    pred_pc = pc_q + 32'd4;
`endif
    fetched = '{pc: pc_q, next_pc: pred_pc, instr: bus.imem_rdata};
  end

  i_fetch_hold_buf u_hold_buf (
    .clk   (clk),
    .rst   (rst),
    .load  (hb_load),
    .clear (hb_clear),
    .din   (fetched),
    .valid (hb_valid),
    .data  (hb_data)
  );

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    pend_d           = pend_q;
    hb_load          = 1'b0;
    hb_clear         = 1'b0;
    bus.imem_read    = 1'b0;
    bus.imem_address = pc_q;
    bus.iq_write     = 1'b0;
    bus.iq_data      = '0;

    unique case (state_q)
      FETCH: begin
        bus.imem_read = 1'b1;
        bus.iq_data   = fetched;
        if (redirect) begin
          // Without a response the cache is mid-transaction: park the target and drain it.
          if (bus.imem_resp) begin
            pc_d = target;
          end else begin
            pend_d  = target;
            state_d = DISCARD;
          end
        end else if (bus.imem_resp) begin
          pc_d = pred_pc;
          if (bus.iq_full) begin
            hb_load = 1'b1;
            state_d = HOLD;
          end else begin
            bus.iq_write = 1'b1;
          end
        end
      end

      DISCARD: begin
        bus.imem_read = 1'b1;
        if (redirect) pend_d = target;
        if (bus.imem_resp) begin
          pc_d    = redirect ? target : pend_q;
          state_d = FETCH;
        end
      end

      HOLD: begin
        bus.iq_data = hb_data;
        if (redirect) begin
          hb_clear = 1'b1;
          pc_d     = target;
          state_d  = FETCH;
        end else if (!bus.iq_full || !hb_valid) begin
          bus.iq_write = hb_valid;
          hb_clear     = 1'b1;
          state_d      = FETCH;
        end
      end

      default: state_d = FETCH;
    endcase

    if (rst) begin
      bus.imem_read    = 1'b0;
      bus.imem_address = RESET_PC;
      bus.iq_write     = 1'b0;
      bus.iq_data      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_i_fetch.sv
// Directed bench for i_fetch: stream, back-pressure, redirects, wrap and JAL prediction.
module tb_i_fetch;
  import i_fetch_pkg::*;

`ifdef IFETCH_JAL_PREDICT_EN
  localparam logic [31:0] JAL_EXP = 32'h0000_0070;
`else
  localparam logic [31:0] JAL_EXP = 32'h0000_0064;
`endif

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  int          checks;
  int          errors;
  int          wr_cnt;
  int          n;

  i_fetch_if bus ();

  i_fetch #(.RESET_PC(32'h0000_0060)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial wr_cnt = 0;
  always @(negedge clk) if (!rst && bus.iq_write === 1'b1) wr_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fetch_one(input logic [31:0] pc, input logic [31:0] word,
                           input logic [31:0] npc);
    #1;
    chk("req_read", {31'd0, bus.imem_read}, 32'd1);
    chk("req_addr", bus.imem_address, pc);
    chk("req_nowrite", {31'd0, bus.iq_write}, 32'd0);
    tick();
    bus.imem_resp  = 1'b1;
    bus.imem_rdata = word;
    #1;
    chk("wr_strobe", {31'd0, bus.iq_write}, 32'd1);
    chk("wr_pc", bus.iq_data.pc, pc);
    chk("wr_next_pc", bus.iq_data.next_pc, npc);
    chk("wr_instr", bus.iq_data.instr, word);
    tick();
    bus.imem_resp  = 1'b0;
    bus.imem_rdata = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    bus.imem_resp = 1'b0;
    bus.imem_rdata = '0;
    bus.iq_full = 1'b0;

    tick();
    tick();
    chk("rst_read", {31'd0, bus.imem_read}, 32'd0);
    chk("rst_write", {31'd0, bus.iq_write}, 32'd0);
    chk("rst_addr", bus.imem_address, 32'h60);
    chk("rst_data_pc", bus.iq_data.pc, 32'h0);
    chk("rst_data_instr", bus.iq_data.instr, 32'h0);
    rst = 1'b0;

    // stream
    fetch_one(32'h60, 32'h0000_0013, 32'h64);
    fetch_one(32'h64, 32'h0000_0013, 32'h68);
    fetch_one(32'h68, 32'h0000_0013, 32'h6C);
    chk("stream_count", wr_cnt, 32'd3);

    // back-pressure
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fetch_one(32'h60, 32'h0000_0013, 32'h64);
    #1 chk("bp_addr", bus.imem_address, 32'h64);
    tick();
    bus.imem_resp = 1'b1; bus.imem_rdata = 32'h0010_0093; bus.iq_full = 1'b1;
    #1 chk("bp_resp_nowrite", {31'd0, bus.iq_write}, 32'd0);
    tick();
    bus.imem_resp = 1'b0; bus.imem_rdata = '0;
    #1;
    chk("hold_read1", {31'd0, bus.imem_read}, 32'd0);
    chk("hold_nowrite1", {31'd0, bus.iq_write}, 32'd0);
    n = wr_cnt;
    tick();
    chk("hold_read2", {31'd0, bus.imem_read}, 32'd0);
    tick();
    bus.iq_full = 1'b0;
    #1;
    chk("hold_release_write", {31'd0, bus.iq_write}, 32'd1);
    chk("hold_pc", bus.iq_data.pc, 32'h64);
    chk("hold_next_pc", bus.iq_data.next_pc, 32'h68);
    chk("hold_instr", bus.iq_data.instr, 32'h0010_0093);
    chk("hold_release_read", {31'd0, bus.imem_read}, 32'd0);
    tick();
    chk("after_hold_read", {31'd0, bus.imem_read}, 32'd1);
    chk("after_hold_addr", bus.imem_address, 32'h68);
    chk("after_hold_nowrite", {31'd0, bus.iq_write}, 32'd0);
    chk("hold_one_write", wr_cnt, n + 1);
    fetch_one(32'h68, 32'h0000_0013, 32'h6C);
    fetch_one(32'h6C, 32'h0000_0013, 32'h70);

    // redirect while read for 0x70 is outstanding
    redirect = 1'b1; redirect_pc = 32'h200;
    #1;
    chk("redir_nowrite", {31'd0, bus.iq_write}, 32'd0);
    chk("redir_addr", bus.imem_address, 32'h70);
    n = wr_cnt;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("discard_addr", bus.imem_address, 32'h70);
      chk("discard_read", {31'd0, bus.imem_read}, 32'd1);
      tick();
    end
    bus.imem_resp = 1'b1; bus.imem_rdata = 32'h0000_0013;
    #1;
    chk("discard_drop", {31'd0, bus.iq_write}, 32'd0);
    chk("discard_resp_addr", bus.imem_address, 32'h70);
    tick();
    bus.imem_resp = 1'b0;
    #1;
    chk("discard_new_addr", bus.imem_address, 32'h200);
    chk("discard_no_write", wr_cnt, n);

    // redirect with response in the same cycle
    tick();
    bus.imem_resp = 1'b1; redirect = 1'b1; redirect_pc = 32'h300;
    #1 chk("simul_nowrite", {31'd0, bus.iq_write}, 32'd0);
    tick();
    bus.imem_resp = 1'b0; redirect = 1'b0;
    #1 chk("simul_addr", bus.imem_address, 32'h300);

    // redirect during HOLD; low bits of redirect_pc ignored
    tick();
    bus.imem_resp = 1'b1; bus.iq_full = 1'b1; bus.imem_rdata = 32'h0000_0013;
    #1 chk("hr_nowrite", {31'd0, bus.iq_write}, 32'd0);
    n = wr_cnt;
    tick();
    bus.imem_resp = 1'b0;
    #1 chk("hr_hold_read", {31'd0, bus.imem_read}, 32'd0);
    tick();
    bus.iq_full = 1'b0; redirect = 1'b1; redirect_pc = 32'h103;
    #1 chk("hr_redir_nowrite", {31'd0, bus.iq_write}, 32'd0);
    tick();
    redirect = 1'b0;
    fetch_one(32'h100, 32'h0000_0013, 32'h104);
    chk("hr_buffer_dropped", wr_cnt, n + 1);

    // two redirects while discarding: later one wins
    redirect = 1'b1; redirect_pc = 32'h400;
    #1 chk("dbl_addr1", bus.imem_address, 32'h104);
    tick();
    redirect_pc = 32'h500;
    #1 chk("dbl_addr2", bus.imem_address, 32'h104);
    tick();
    redirect = 1'b0; bus.imem_resp = 1'b1;
    #1 chk("dbl_drop", {31'd0, bus.iq_write}, 32'd0);
    tick();
    bus.imem_resp = 1'b0;
    fetch_one(32'h500, 32'h0000_0013, 32'h504);

    // redirect in DISCARD coinciding with the response
    redirect = 1'b1; redirect_pc = 32'h600;
    tick();
    redirect_pc = 32'h700; bus.imem_resp = 1'b1;
    #1 chk("dsim_nowrite", {31'd0, bus.iq_write}, 32'd0);
    tick();
    redirect = 1'b0; bus.imem_resp = 1'b0;
    fetch_one(32'h700, 32'h0000_0013, 32'h704);

    // PC wrap
    bus.imem_resp = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    bus.imem_resp = 1'b0; redirect = 1'b0;
    fetch_one(32'hFFFF_FFFC, 32'h0000_0013, 32'h0);
    fetch_one(32'h0, 32'h0000_0013, 32'h4);

    // JAL x0,+16 at 0x60
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fetch_one(32'h60, 32'h0100_006F, JAL_EXP);
    #1;
    chk("jal_next_addr", bus.imem_address, JAL_EXP);
    chk("jal_next_read", {31'd0, bus.imem_read}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
